// File: rtl/voq_scheduler.sv
// Centralized PORT_CNT x PORT_CNT crossbar scheduler: snapshots the VOQ empty
// vectors, builds a round-robin matching one egress per cycle, then issues and holds it.
module voq_scheduler #(
  parameter  int PORT_CNT    = 4,
  parameter  int SLOT_CYCLES = 4,
  localparam int SEL_W       = $clog2(PORT_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          experimenting,
  input  logic [PORT_CNT*PORT_CNT-1:0]  is_empty,
  output logic [PORT_CNT-1:0]           sched_en,
  output logic [PORT_CNT*SEL_W-1:0]     sched_sel,
  output logic [PORT_CNT*SEL_W-1:0]     xbar_sel,
  output logic [PORT_CNT-1:0]           xbar_valid,
  output logic                          slot_start,
  output logic                          busy
);

  localparam int HOLD_W = $clog2(SLOT_CYCLES);

  typedef enum logic [1:0] {IDLE, MATCH, ISSUE, HOLD} state_t;

  state_t                             state;
  logic [PORT_CNT*PORT_CNT-1:0]       snap;
  logic [PORT_CNT-1:0]                matched_in;
  logic [PORT_CNT-1:0]                matched_out;
  logic [PORT_CNT-1:0][SEL_W-1:0]     match;
  logic [PORT_CNT-1:0][SEL_W-1:0]     src;
  logic [PORT_CNT-1:0][SEL_W-1:0]     rr_ptr;
  logic [PORT_CNT-1:0][SEL_W-1:0]     sched_sel_q;
  logic [PORT_CNT-1:0][SEL_W-1:0]     xbar_sel_q;
  logic [SEL_W-1:0]                   start_egress;
  logic [SEL_W-1:0]                   step_cnt;
  logic [HOLD_W-1:0]                  hold_cnt;

  logic [SEL_W-1:0]                   cur_e;
  logic [SEL_W-1:0]                   scan_i;
  logic [SEL_W-1:0]                   grant_i;
  logic                               grant_vld;
  logic [PORT_CNT-1:0]                matched_in_nxt;
  logic [PORT_CNT-1:0][SEL_W-1:0]     match_nxt;
  logic                               hold_last;
  logic                               start_slot;

  function automatic logic [SEL_W-1:0] mod_add(input logic [SEL_W-1:0] a,
                                               input logic [SEL_W-1:0] b);
    logic [SEL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (SEL_W+1)'(PORT_CNT)) s = s - (SEL_W+1)'(PORT_CNT);
    return s[SEL_W-1:0];
  endfunction

  assign hold_last  = (hold_cnt == HOLD_W'(SLOT_CYCLES - 1));
  assign start_slot = experimenting && ((state == IDLE) || ((state == HOLD) && hold_last));
  assign busy       = (state != IDLE);
  assign sched_sel  = sched_sel_q;
  assign xbar_sel   = xbar_sel_q;

  // One egress per MATCH cycle: first unmatched, non-empty ingress from rr_ptr upward.
  // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    cur_e     = mod_add(start_egress, step_cnt);
    grant_vld = 1'b0;
    grant_i   = '0;
    scan_i    = '0;
    for (int j = 0; j < PORT_CNT; j++) begin
      scan_i = mod_add(rr_ptr[cur_e], SEL_W'(j));
      if (!grant_vld && !matched_out[cur_e] && !matched_in[scan_i] &&
          !snap[int'(scan_i)*PORT_CNT + int'(cur_e)]) begin
        grant_vld = 1'b1;
        grant_i   = scan_i;
      end
    end
    matched_in_nxt = matched_in;
    match_nxt      = match;
    if (grant_vld) begin
      matched_in_nxt[grant_i] = 1'b1;
      match_nxt[grant_i]      = cur_e;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override earlier defaults.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      // NOTE: the small match/snapshot arrays are reset too, so nothing stale can leak into a slot.
      snap         <= '0;
      matched_in   <= '0;
      matched_out  <= '0;
      match        <= '0;
      src          <= '0;
      rr_ptr       <= '0;
      sched_sel_q  <= '0;
      xbar_sel_q   <= '0;
      start_egress <= '0;
      step_cnt     <= '0;
      hold_cnt     <= '0;
      sched_en     <= '0;
      xbar_valid   <= '0;
      slot_start   <= 1'b0;
    end else begin
      slot_start <= start_slot;
      sched_en   <= '0;
      if (start_slot) begin
        state       <= MATCH;
        snap        <= is_empty;
        matched_in  <= '0;
        matched_out <= '0;
        step_cnt    <= '0;
      end
      case (state)
        IDLE: ;
        MATCH: begin
          if (grant_vld) begin
            match[grant_i]      <= cur_e;
            src[cur_e]          <= grant_i;
            matched_in[grant_i] <= 1'b1;
            matched_out[cur_e]  <= 1'b1;
            rr_ptr[cur_e]       <= mod_add(grant_i, SEL_W'(1));
          end
          if (step_cnt == SEL_W'(PORT_CNT - 1)) begin
            state    <= ISSUE;
            sched_en <= matched_in_nxt;
            for (int i = 0; i < PORT_CNT; i++)
              if (matched_in_nxt[i]) sched_sel_q[i] <= match_nxt[i];
          end else begin
            step_cnt <= step_cnt + SEL_W'(1);
          end
        end
        ISSUE: begin
          for (int e = 0; e < PORT_CNT; e++) begin
            xbar_valid[e] <= matched_out[e];
            if (matched_out[e]) xbar_sel_q[e] <= src[e];
          end
          hold_cnt <= '0;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_last) begin
            xbar_valid   <= '0;
            start_egress <= mod_add(start_egress, SEL_W'(1));
            if (!experimenting) state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voq_scheduler.sv
// Directed bench for voq_scheduler at default parameters (4x4, 4-cycle hold, 9-cycle slot).
module tb_voq_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        experimenting;
  logic [15:0] is_empty;
  logic [3:0]  sched_en;
  logic [7:0]  sched_sel;
  logic [7:0]  xbar_sel;
  logic [3:0]  xbar_valid;
  logic        slot_start;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  voq_scheduler #(.PORT_CNT(4), .SLOT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .experimenting(experimenting), .is_empty(is_empty),
    .sched_en(sched_en), .sched_sel(sched_sel), .xbar_sel(xbar_sel),
    .xbar_valid(xbar_valid), .slot_start(slot_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    experimenting = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Entered on the first MATCH cycle; walks the 9-cycle slot and ends on the following cycle.
  task automatic run_slot(input string tag, input logic [3:0] exp_en, input logic [7:0] exp_sel,
                          input logic [3:0] exp_xv, input logic [7:0] xs_mask,
                          input logic [7:0] exp_xs, input logic [15:0] next_empty,
                          input logic next_exp, input logic exp_next);
    int en_cyc = 0;
    int xv_cyc = 0;
    check({tag, ".slot_start"}, 32'(slot_start), 32'd1);
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 1) begin
        is_empty      = next_empty;
        experimenting = next_exp;
      end
      if (sched_en != 4'd0) en_cyc++;
      if (xbar_valid != 4'd0) xv_cyc++;
      if (c == 4) begin
        check({tag, ".sched_en"},  32'(sched_en),  32'(exp_en));
        check({tag, ".sched_sel"}, 32'(sched_sel), 32'(exp_sel));
      end
      if (c == 5) begin
        check({tag, ".xbar_valid"}, 32'(xbar_valid), 32'(exp_xv));
        if (xs_mask != 8'd0) check({tag, ".xbar_sel"}, 32'(xbar_sel & xs_mask), 32'(exp_xs));
      end
      if (c == 9) begin
        check({tag, ".next_slot_start"}, 32'(slot_start), 32'(exp_next));
        check({tag, ".busy_after"},      32'(busy),       32'(exp_next));
        check({tag, ".xbar_cleared"},    32'(xbar_valid), 32'd0);
      end
    end
    check({tag, ".en_cycles"}, 32'(en_cyc), (exp_en != 4'd0) ? 32'd1 : 32'd0);
    check({tag, ".xv_cycles"}, 32'(xv_cyc), (exp_xv != 4'd0) ? 32'd4 : 32'd0);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      step();
      seen = seen | busy | slot_start | (|sched_en);
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    experimenting = 1'b0;
    is_empty      = 16'hFFFF;
    #1;
    check("rst.outputs", {8'(sched_en), sched_sel, xbar_sel, 4'(xbar_valid),
                          2'(slot_start), 2'(busy)}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("rst.idle", 3);

    // Identity traffic: ingress i holds cells only for egress i.
    is_empty      = 16'h7BDE;
    experimenting = 1'b1;
    step();
    run_slot("ident", 4'hF, 8'hE4, 4'hF, 8'hFF, 8'hE4, 16'h7BDE, 1'b0, 1'b0);
    expect_idle("ident.idle", 10);

    // Asynchronous reset in the middle of HOLD.
    do_reset();
    is_empty      = 16'h7BDE;
    experimenting = 1'b1;
    step();
    check("mid.slot_start", 32'(slot_start), 32'd1);
    repeat (5) step();
    check("mid.xbar_valid", 32'(xbar_valid), 32'hF);
    #2 rst_n = 1'b0;
    #1;
    check("mid.xbar_valid_rst", 32'(xbar_valid), 32'd0);
    check("mid.xbar_sel_rst",   32'(xbar_sel),   32'd0);
    check("mid.sel_rst",        32'(sched_sel),  32'd0);
    check("mid.busy_rst",       32'({busy, slot_start, sched_en}), 32'd0);
    experimenting = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle("mid.idle", 6);

    // Hotspot: every ingress wants only egress 2; rr_ptr[2] should rotate 0,1,2,3.
    is_empty      = 16'hBBBB;
    experimenting = 1'b1;
    step();
    run_slot("hot0", 4'b0001, 8'h02, 4'b0100, 8'h30, 8'h00, 16'hBBBB, 1'b1, 1'b1);
    run_slot("hot1", 4'b0010, 8'h0A, 4'b0100, 8'h30, 8'h10, 16'hBBBB, 1'b1, 1'b1);
    run_slot("hot2", 4'b0100, 8'h2A, 4'b0100, 8'h30, 8'h20, 16'hBBBB, 1'b1, 1'b1);
    run_slot("hot3", 4'b1000, 8'hAA, 4'b0100, 8'h30, 8'h30, 16'hBBBB, 1'b0, 1'b0);
    expect_idle("hot.idle", 10);

    // Full contention, then an all-empty slot, then contention with rotated pointers and a drop.
    do_reset();
    is_empty      = 16'h0000;
    experimenting = 1'b1;
    step();
    run_slot("full0", 4'hF, 8'hE4, 4'hF, 8'hFF, 8'hE4, 16'hFFFF, 1'b1, 1'b1);
    run_slot("empty", 4'h0, 8'hE4, 4'h0, 8'h00, 8'h00, 16'h0000, 1'b1, 1'b1);
    run_slot("full2", 4'hF, 8'h93, 4'hF, 8'hFF, 8'h39, 16'h0000, 1'b0, 1'b0);
    expect_idle("drop.idle", 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
